// File: rtl/seg_scan_ctrl_if.sv
// Host/display bundle for the multiplexed 7-segment scan controller.
// master = host side driving glyphs and load, slave = the controller.
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic [6*NUM_DIGITS-1:0] codes;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   blink_en;
  logic [3:0]              brightness;
  logic                    load;
  logic                    load_ack;
  logic [NUM_DIGITS-1:0]   dig;
  logic [7:0]              seg;
  logic                    frame_start;

  modport master (
    output codes, dp, blink_en, brightness, load,
    input  load_ack, dig, seg, frame_start
  );

  modport slave (
    input  codes, dp, blink_en, brightness, load,
    output load_ack, dig, seg, frame_start
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: time-slices NUM_DIGITS digits,
// double-buffers the display data so updates land only on frame boundaries,
// and applies PWM brightness plus per-digit blink.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 10000,
  parameter int BLINK_DIV      = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  seg_scan_ctrl_if.slave bus
);

  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [NUM_DIGITS-1:0] DIG_OFF = DIG_ACTIVE_LOW ? '1 : '0;
  localparam logic [7:0]            SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

  typedef struct packed {
    logic [6*NUM_DIGITS-1:0] codes;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blink_en;
    logic [3:0]              bri;
  } disp_cfg_t;

  localparam disp_cfg_t CFG_RST = '{codes: '0, dp: '0, blink_en: '0, bri: 4'hF};

  // Glyph table, active-high g..a: 0 blank, 1..9 digits, 10 is zero,
  // 11..36 letters A..Z, anything above blank.
  function automatic logic [6:0] glyph(input logic [5:0] c);
    case (c)
      6'd1:  glyph = 7'h06;  6'd2:  glyph = 7'h5B;  6'd3:  glyph = 7'h4F;
      6'd4:  glyph = 7'h66;  6'd5:  glyph = 7'h6D;  6'd6:  glyph = 7'h7D;
      6'd7:  glyph = 7'h07;  6'd8:  glyph = 7'h7F;  6'd9:  glyph = 7'h6F;
      6'd10: glyph = 7'h3F;  6'd11: glyph = 7'h77;  6'd12: glyph = 7'h7C;
      6'd13: glyph = 7'h39;  6'd14: glyph = 7'h5E;  6'd15: glyph = 7'h79;
      6'd16: glyph = 7'h71;  6'd17: glyph = 7'h3D;  6'd18: glyph = 7'h76;
      6'd19: glyph = 7'h30;  6'd20: glyph = 7'h1E;  6'd21: glyph = 7'h75;
      6'd22: glyph = 7'h38;  6'd23: glyph = 7'h37;  6'd24: glyph = 7'h54;
      6'd25: glyph = 7'h5C;  6'd26: glyph = 7'h73;  6'd27: glyph = 7'h67;
      6'd28: glyph = 7'h50;  6'd29: glyph = 7'h6D;  6'd30: glyph = 7'h78;
      6'd31: glyph = 7'h3E;  6'd32: glyph = 7'h1C;  6'd33: glyph = 7'h7E;
      6'd34: glyph = 7'h49;  6'd35: glyph = 7'h6E;  6'd36: glyph = 7'h5B;
      default: glyph = 7'h00;
    endcase
  endfunction

  logic [SW-1:0]         slot_q, slot_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [BW-1:0]         blk_cnt_q, blk_cnt_d;
  logic                  phase_q, phase_d;
  logic                  pend_q, pend_d;
  disp_cfg_t             pend_buf_q, pend_buf_d;
  disp_cfg_t             act_q, act_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;
  logic [7:0]            seg_q, seg_d;
  logic                  fs_q, fs_d;
  logic                  ack_q, ack_d;

  disp_cfg_t             live;
  logic                  slot_last, idx_last, boundary;
  logic [5:0]            cur_code;
  logic                  cur_dp, cur_blk, en;
  logic [SW-1:0]         on_cycles;
  logic [NUM_DIGITS-1:0] dig_lit;
  logic [7:0]            seg_lit;

  assign live = '{codes: bus.codes, dp: bus.dp, blink_en: bus.blink_en, bri: bus.brightness};

  // Scan position, blink phase and the pending/active double buffer.
  always_comb begin
    slot_d     = slot_q;
    idx_d      = idx_q;
    blk_cnt_d  = blk_cnt_q;
    phase_d    = phase_q;
    pend_d     = pend_q;
    pend_buf_d = pend_buf_q;
    act_d      = act_q;
    ack_d      = 1'b0;

    slot_last = (slot_q == SW'(SCAN_DIV - 1));
    idx_last  = (idx_q == IW'(NUM_DIGITS - 1));
    boundary  = slot_last && idx_last;

    if (slot_last) begin
      slot_d = '0;
      idx_d  = idx_last ? '0 : idx_q + IW'(1);
    end else begin
      slot_d = slot_q + SW'(1);
    end

    if (bus.load) pend_buf_d = live;

    if (boundary) begin
      if (blk_cnt_q == BW'(BLINK_DIV - 1)) begin
        blk_cnt_d = '0;
        phase_d   = ~phase_q;
      end else begin
        blk_cnt_d = blk_cnt_q + BW'(1);
      end
      // A load landing on the boundary itself wins over the older pending copy.
      if (bus.load)   act_d = live;
      else if (pend_q) act_d = pend_buf_q;
      ack_d  = bus.load || pend_q;
      pend_d = 1'b0;
    end else if (bus.load) begin
      pend_d = 1'b1;
    end
  end

  // Display decode for the current slot; registered so dig/seg/frame_start align.
  always_comb begin
    cur_code = '0;
    cur_dp   = 1'b0;
    cur_blk  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_code = act_q.codes[6*i +: 6];
        cur_dp   = act_q.dp[i];
        cur_blk  = act_q.blink_en[i];
      end
    end
    on_cycles = (act_q.bri == 4'hF) ? SW'(SCAN_DIV) : SW'(act_q.bri) * SW'(SCAN_DIV / 16);
    en        = (slot_q < on_cycles) && !(phase_q && cur_blk);
    dig_lit   = en ? (NUM_DIGITS'(1) << idx_q) : '0;
    seg_lit   = en ? {cur_dp, glyph(cur_code)} : 8'h00;
    dig_d     = DIG_ACTIVE_LOW ? ~dig_lit : dig_lit;
    seg_d     = SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
    fs_d      = (slot_q == '0) && (idx_q == '0);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q     <= '0;
      idx_q      <= '0;
      blk_cnt_q  <= '0;
      phase_q    <= 1'b0;
      pend_q     <= 1'b0;
      pend_buf_q <= CFG_RST;
      act_q      <= CFG_RST;
      dig_q      <= DIG_OFF;
      seg_q      <= SEG_OFF;
      fs_q       <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      idx_q      <= idx_d;
      blk_cnt_q  <= blk_cnt_d;
      phase_q    <= phase_d;
      pend_q     <= pend_d;
      pend_buf_q <= pend_buf_d;
      act_q      <= act_d;
      dig_q      <= dig_d;
      seg_q      <= seg_d;
      fs_q       <= fs_d;
      ack_q      <= ack_d;
    end
  end

  assign bus.dig         = dig_q;
  assign bus.seg         = seg_q;
  assign bus.frame_start = fs_q;
  assign bus.load_ack    = ack_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: 4 digits, 32-cycle slots, blink every
// 2 frames, active-low segments and digits.
module tb_seg_scan_ctrl;

  logic clk;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   ack_cnt  = 0;

  seg_scan_ctrl_if #(.NUM_DIGITS(4)) bus ();

  seg_scan_ctrl #(
    .NUM_DIGITS(4), .SCAN_DIV(32), .BLINK_DIV(2),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [23:0] C_DEMO = {6'd2, 6'd1, 6'd8, 6'd10};
  localparam logic [23:0] C_ONES = {6'd1, 6'd1, 6'd1, 6'd1};
  localparam logic [23:0] C_3456 = {6'd6, 6'd5, 6'd4, 6'd3};
  localparam logic [31:0] S_DEMO = 32'hA4_F9_80_C0;
  localparam logic [31:0] S_DEMO_DP0 = 32'hA4_F9_80_40;
  localparam logic [31:0] S_3456 = 32'h82_92_99_B0;
  localparam logic [31:0] S_BLANK = 32'hFF_FF_FF_FF;

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.load_ack) ack_cnt++;
    n_assert++;
    assert (($countones(~bus.dig) <= 1) === 1'b1) else begin
      n_fail++;
      $error("FAIL onehot dig=%b exp at most one low bit", bus.dig);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!bus.frame_start && n < 400);
    n_assert++;
    assert (bus.frame_start === 1'b1) else begin
      n_fail++;
      $error("FAIL frame_timeout got frame_start=%b exp 1 within 400 cycles", bus.frame_start);
    end
  endtask

  // Called on the cycle frame_start is visible; ends on the next frame's first cycle.
  task automatic check_frame(input string tag, input logic [31:0] segs,
                             input logic [3:0] bri, input logic [3:0] dark);
    logic       en;
    logic [3:0] one;
    logic [3:0] edig;
    logic [7:0] eseg;
    logic       efs;
    one = 4'b0001;
    for (int d = 0; d < 4; d++) begin
      for (int s = 0; s < 32; s++) begin
        en   = ((bri == 4'hF) || (s < bri * 2)) && !dark[d];
        edig = en ? ~(one << d) : 4'hF;
        eseg = en ? segs[8*d +: 8] : 8'hFF;
        efs  = (d == 0) && (s == 0);
        n_assert++;
        assert ({bus.dig, bus.seg, bus.frame_start} === {edig, eseg, efs}) else begin
          n_fail++;
          $error("FAIL %s d=%0d s=%0d got dig=%h seg=%h fs=%b exp dig=%h seg=%h fs=%b",
                 tag, d, s, bus.dig, bus.seg, bus.frame_start, edig, eseg, efs);
        end
        tick();
      end
    end
  endtask

  task automatic drive(input logic [23:0] c, input logic [3:0] dpv,
                       input logic [3:0] blk, input logic [3:0] bri);
    bus.codes      = c;
    bus.dp         = dpv;
    bus.blink_en   = blk;
    bus.brightness = bri;
  endtask

  initial begin
    rst      = 1'b1;
    bus.load = 1'b1;
    drive(C_ONES, 4'h0, 4'h0, 4'hF);

    // Reset holds outputs dark and wins over a concurrent load.
    repeat (3) tick();
    chk("rst_dig", 32'(bus.dig), 32'hF);
    chk("rst_seg", 32'(bus.seg), 32'hFF);
    chk("rst_ack", 32'(bus.load_ack), 32'h0);
    chk("rst_fs", 32'(bus.frame_start), 32'h0);
    rst      = 1'b0;
    bus.load = 1'b0;
    tick();
    chk("first_fs", 32'(bus.frame_start), 32'h1);
    check_frame("blank_f0", S_BLANK, 4'hF, 4'h0);
    check_frame("blank_f1", S_BLANK, 4'hF, 4'h0);
    chk("rst_load_discard", 32'(ack_cnt), 32'd0);

    // Basic load: visible only from the next frame.
    drive(C_DEMO, 4'h0, 4'h0, 4'hF);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    repeat (40) tick();
    chk("midframe_hold", {20'h0, bus.dig, bus.seg}, {20'h0, 4'hD, 8'hFF});
    wait_frame();
    check_frame("demo_b15", S_DEMO, 4'hF, 4'h0);
    chk("ack_cnt1", 32'(ack_cnt), 32'd1);

    // Brightness 4 then 0.
    drive(C_DEMO, 4'h0, 4'h0, 4'h4);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    wait_frame();
    check_frame("demo_b4", S_DEMO, 4'h4, 4'h0);
    drive(C_DEMO, 4'h0, 4'h0, 4'h0);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    wait_frame();
    check_frame("demo_b0", S_DEMO, 4'h0, 4'h0);
    chk("ack_cnt3", 32'(ack_cnt), 32'd3);

    // Two loads in one frame: last one wins, single ack.
    drive(C_ONES, 4'h0, 4'h0, 4'hF);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    repeat (20) tick();
    chk("dbl_hold_dark", 32'(bus.dig), 32'hF);
    drive(C_DEMO, 4'h0, 4'h0, 4'hF);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    wait_frame();
    check_frame("dbl_second", S_DEMO, 4'hF, 4'h0);
    chk("ack_cnt4", 32'(ack_cnt), 32'd4);

    // Load exactly on the boundary cycle (state is one slot ahead of outputs).
    repeat (126) tick();
    drive(C_3456, 4'h0, 4'h0, 4'hF);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    chk("bnd_ack", 32'(bus.load_ack), 32'h1);
    tick();
    check_frame("bnd_data", S_3456, 4'hF, 4'h0);
    chk("ack_cnt5", 32'(ack_cnt), 32'd5);

    // Reset mid-slot with a load pending.
    drive(C_ONES, 4'h0, 4'h0, 4'hF);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    chk("rst2_dig_seg", {20'h0, bus.dig, bus.seg}, {20'h0, 4'hF, 8'hFF});
    chk("rst2_ack", 32'(bus.load_ack), 32'h0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check_frame("rst2_f0", S_BLANK, 4'hF, 4'h0);
    check_frame("rst2_f1", S_BLANK, 4'hF, 4'h0);
    chk("rst2_no_ack", 32'(ack_cnt), 32'd5);

    // Blink on digit 0 with its decimal point; phase flips every 2 frames.
    drive(C_DEMO, 4'h1, 4'h1, 4'hF);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    wait_frame();
    check_frame("blink_f3", S_DEMO_DP0, 4'hF, 4'h1);
    check_frame("blink_f4", S_DEMO_DP0, 4'hF, 4'h0);
    check_frame("blink_f5", S_DEMO_DP0, 4'hF, 4'h0);
    check_frame("blink_f6", S_DEMO_DP0, 4'hF, 4'h1);
    check_frame("blink_f7", S_DEMO_DP0, 4'hF, 4'h1);
    chk("ack_cnt6", 32'(ack_cnt), 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
